// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the ALU control decoder, plus exec-unit FSM state encoding
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_e;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: op channel (in_valid/in_ready, alu_ctl, a, b) and result channel (out_valid/out_ready, result, zero, illegal); master = producer/consumer, slave = ALU
interface alu_exec_unit_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  modport master (output in_valid, alu_ctl, a, b, out_ready, input in_ready, out_valid, result, zero, illegal);
  modport slave (input in_valid, alu_ctl, a, b, out_ready, output in_ready, out_valid, result, zero, illegal);
endinterface

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative 1-bit/cycle SLL/SRL/SRA; ports clock, reset, start/op/a/shamt in, done/value out
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [WIDTH-1:0]   value
);
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  always_comb begin
    op_d   = start ? op : op_q;
    cnt_d  = start ? shamt : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    work_d = start ? a :
             (cnt_q == '0) ? work_q :
             (op_q == ALU_SLL) ? work_q << 1 :
             (op_q == ALU_SRL) ? work_q >> 1 :
             {work_q[WIDTH-1], work_q[WIDTH-1:1]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end
  assign done  = (cnt_q == '0);
  assign value = work_q;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU; ports clock, reset, alu_exec_unit_if.slave bus; iterative shifts built only with ALU_SHIFT_EN
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic          clock,
  input  logic          reset,
  alu_exec_unit_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, op_res;
  logic             zero_q, zero_d, illegal_q, illegal_d, op_ill, is_shift, acc;
  logic             sh_done;
  logic [WIDTH-1:0] sh_val;
`ifdef ALU_SHIFT_EN
  localparam int SHAMT_W = $clog2(WIDTH);
  logic [SHAMT_W-1:0] shamt;
  assign shamt    = bus.b[SHAMT_W-1:0];
  assign is_shift = (bus.alu_ctl == ALU_SLL || bus.alu_ctl == ALU_SRL || bus.alu_ctl == ALU_SRA) && shamt != '0;
  alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
    .clock (clock),
    .reset (reset),
    .start (acc && is_shift),
    .op    (bus.alu_ctl),
    .a     (bus.a),
    .shamt (shamt),
    .done  (sh_done),
    .value (sh_val)
  );
`else
  assign is_shift = 1'b0;
  assign sh_done  = 1'b0;
  assign sh_val   = '0;
`endif
  assign bus.in_ready = (state_q == S_IDLE) || (state_q == S_HOLD && bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (bus.alu_ctl)
      ALU_AND: op_res = bus.a & bus.b;
      ALU_OR:  op_res = bus.a | bus.b;
      ALU_ADD: op_res = bus.a + bus.b;
      ALU_SUB: op_res = bus.a - bus.b;
      ALU_SLT: op_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      ALU_NOR: op_res = ~(bus.a | bus.b);
`ifdef ALU_SHIFT_EN
      // shamt==0 completes here in one cycle; nonzero amounts go through the iterator
      ALU_SLL: op_res = bus.a << shamt;
      ALU_SRL: op_res = bus.a >> shamt;
      ALU_SRA: op_res = WIDTH'($signed(bus.a) >>> shamt);
`endif
      default: op_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (acc) begin
      state_d = is_shift ? S_SHIFT : S_HOLD;
      if (!is_shift) begin
        result_d  = op_res;
        zero_d    = (op_res == '0);
        illegal_d = op_ill;
      end
    end else if (state_q == S_HOLD && bus.out_ready) begin
      state_d = S_IDLE;
    end else if (state_q == S_SHIFT && sh_done) begin
      state_d   = S_HOLD;
      result_d  = sh_val;
      zero_d    = (sh_val == '0);
      illegal_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  alu_exec_unit_if #(.WIDTH(64)) bus ();
  alu_exec_unit #(.WIDTH(64)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b);
    bus.alu_ctl  = ctl;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask
  logic [3:0]  v_ctl [4];
  logic [63:0] v_a [4], v_b [4], v_exp [4];
  int n;
  logic seen;
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_ctl   = '0;
    bus.a         = '0;
    bus.b         = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    issue(ALU_OR, 64'h1234, 64'h1);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result", bus.result, 64'd0);
    check("midrst_illegal", 64'(bus.illegal), 64'd0);
    check("midrst_zero", 64'(bus.zero), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    issue(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_result", bus.result, 64'd0);
    check("add_zero", 64'(bus.zero), 64'd1);
    pop();
    check("pop_idle", 64'(bus.out_valid), 64'd0);
    issue(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("slt_result", bus.result, 64'd1);
    pop();
    issue(ALU_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("slt_rev_result", bus.result, 64'd0);
    pop();
    issue(ALU_SUB, 64'd5, 64'd7);
    check("sub_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_zero", 64'(bus.zero), 64'd0);
    pop();
    v_ctl = '{ALU_AND, ALU_OR, ALU_NOR, ALU_SUB};
    v_a   = '{64'hF0F0, 64'h0F0F, 64'h0, 64'd10};
    v_b   = '{64'hFF00, 64'h00F0, 64'h0, 64'd3};
    v_exp = '{64'hF000, 64'h0FFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_ctl  = v_ctl[i];
      bus.a        = v_a[i];
      bus.b        = v_b[i];
      bus.in_valid = 1'b1;
      step();
      check($sformatf("b2b_valid%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("b2b_result%0d", i), bus.result, v_exp[i]);
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    check("b2b_drain", 64'(bus.out_valid), 64'd0);
    issue(ALU_ADD, 64'd2, 64'd3);
    bus.alu_ctl  = ALU_BAD;
    bus.a        = 64'hAAAA;
    bus.b        = 64'h5555;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_in_ready%0d", i), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_result%0d", i), bus.result, 64'd5);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("bad_valid", 64'(bus.out_valid), 64'd1);
    check("bad_result", bus.result, 64'd0);
    check("bad_illegal", 64'(bus.illegal), 64'd1);
    check("bad_zero", 64'(bus.zero), 64'd1);
    step();
    bus.out_ready = 1'b0;
    issue(ALU_AND, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF);
    check("ill_clear", 64'(bus.illegal), 64'd0);
    check("ill_clear_result", bus.result, 64'hFF);
    pop();
`ifdef ALU_SHIFT_EN
    issue(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4);
    check("sra_in_ready", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("sra_latency", 64'(n), 64'd5);
    check("sra_result", bus.result, 64'hF800_0000_0000_0000);
    pop();
    issue(ALU_SLL, 64'd1, 64'd0);
    check("sll0_valid", 64'(bus.out_valid), 64'd1);
    check("sll0_result", bus.result, 64'd1);
    pop();
    issue(ALU_SRL, 64'hF0, 64'd4);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("srl_latency", 64'(n), 64'd5);
    check("srl_result", bus.result, 64'h0F);
    pop();
    issue(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= bus.out_valid;
      step();
    end
    check("sra_rst_no_valid", 64'(seen), 64'd0);
    check("sra_rst_in_ready", 64'(bus.in_ready), 64'd1);
`else
    issue(ALU_SLL, 64'd1, 64'd3);
    check("sll_off_illegal", 64'(bus.illegal), 64'd1);
    check("sll_off_result", bus.result, 64'd0);
    pop();
    issue(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4);
    check("sra_off_valid", 64'(bus.out_valid), 64'd1);
    check("sra_off_illegal", 64'(bus.illegal), 64'd1);
    pop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
